// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order retire into the GPR file.
//
// Entries are allocated in program order at dispatch (tag = tail index).
// Results are captured from the writeback bus. The oldest entry retires
// once it is done, and drives the register-file commit port. Issue can
// look up operands by ROB tag, with same-cycle forwarding from the
// writeback bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard every entry (mispredict/exception)
//   disp_valid/_dst_en/_dst_addr  dispatch request and destination GPR
//   disp_ready, disp_tag     entry available, tag given to this dispatch
//   wb_valid/_tag/_value     writeback bus
//   src1_*/src2_*            operand lookup by tag (ready + value)
//   commit_dst_en, rob_commit_dst_addr/_value  GPR commit write port
//   rob_empty, rob_full      occupancy status
module rob_commit #(
  parameter int DEPTH          = 8,
  parameter int TAG_WIDTH      = 3,
  parameter int WORD_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  input  logic                      disp_dst_en,
  input  logic [GPR_ADDR_WIDTH-1:0] disp_dst_addr,
  output logic                      disp_ready,
  output logic [TAG_WIDTH-1:0]      disp_tag,
  input  logic                      wb_valid,
  input  logic [TAG_WIDTH-1:0]      wb_tag,
  input  logic [WORD_WIDTH-1:0]     wb_value,
  input  logic [TAG_WIDTH-1:0]      src1_tag,
  input  logic [TAG_WIDTH-1:0]      src2_tag,
  output logic                      src1_ready,
  output logic [WORD_WIDTH-1:0]     src1_value,
  output logic                      src2_ready,
  output logic [WORD_WIDTH-1:0]     src2_value,
  output logic                      commit_dst_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr,
  output logic [WORD_WIDTH-1:0]     rob_commit_dst_value,
  output logic                      rob_empty,
  output logic                      rob_full
);

  localparam logic [TAG_WIDTH:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

  // Control state (reset) and per-entry payload (not reset, qualified by valid)
  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          done_q;
  logic [DEPTH-1:0]          dst_en_q;
  logic [GPR_ADDR_WIDTH-1:0] dst_addr_q [DEPTH];
  logic [WORD_WIDTH-1:0]     value_q    [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [TAG_WIDTH:0]   head_q;
  logic [TAG_WIDTH:0]   tail_q;
  logic [TAG_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0] tail_idx;

  logic clear;
  logic dispatch;
  logic wb_hit;
  logic retire;
  logic src1_fwd;
  logic src2_fwd;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];

  assign rob_empty  = (head_q == tail_q);
  assign rob_full   = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  // No credit for a same-cycle retire: a full ROB always blocks dispatch
  assign disp_ready = !rob_full;
  assign disp_tag   = tail_idx;

  // Flush/reset dominate: the cycle they are asserted nothing is allocated,
  // completed or retired.
  assign clear    = rst || flush;
  assign dispatch = disp_valid && disp_ready && !clear;
  assign wb_hit   = wb_valid && valid_q[wb_tag] && !clear;
  // A writeback to the head is only seen through done_q, so it retires
  // on the following cycle rather than combinationally.
  assign retire   = valid_q[head_idx] && done_q[head_idx] && !clear;

  assign commit_dst_en        = retire && dst_en_q[head_idx];
  assign rob_commit_dst_addr  = retire ? dst_addr_q[head_idx] : '0;
  assign rob_commit_dst_value = retire ? value_q[head_idx]    : '0;

  // Operand lookup with forwarding from the writeback bus
  assign src1_fwd   = wb_valid && (wb_tag == src1_tag);
  assign src2_fwd   = wb_valid && (wb_tag == src2_tag);
  assign src1_ready = valid_q[src1_tag] && (done_q[src1_tag] || src1_fwd);
  assign src2_ready = valid_q[src2_tag] && (done_q[src2_tag] || src2_fwd);
  assign src1_value = src1_fwd ? wb_value : value_q[src1_tag];
  assign src2_value = src2_fwd ? wb_value : value_q[src2_tag];

  // Control state update. Retire is applied after writeback so a
  // retiring head always ends up invalid and not done.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (wb_hit) begin
        done_q[wb_tag] <= 1'b1;
      end
      if (retire) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
      // Dispatch targets tail, which is never the head of a non-empty,
      // non-full ROB, nor a valid writeback target.
      if (dispatch) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + PTR_ONE;
      end
    end
  end

  // Entry payload update; x0 destinations are never committed
  always_ff @(posedge clk) begin
    if (dispatch) begin
      dst_en_q[tail_idx]   <= disp_dst_en && (disp_dst_addr != '0);
      dst_addr_q[tail_idx] <= disp_dst_addr;
    end
    if (wb_hit) begin
      value_q[wb_tag] <= wb_value;
    end
  end

endmodule
